train_sample_sequencer: RTL and testbench
=========================================

Name: train_sample_sequencer

Overview:
- Producer side of the training-sample stream consumed by the perceptron trainer.
- Holds a small writable dataset of (x1, x2, target) fixed-point samples and replays it for a programmed number of epochs.
- Drives a valid/ready stream so that each sample is held until it is accepted.
- Sits between the host/load logic and the neuron trainer's train_x1/x2/out and valid inputs.

Parameters:
- SIGN, 1, sign bits of the fixed-point word
- Q_M, 15, integer bits
- Q_N, 16, fraction bits; data width W = SIGN+Q_M+Q_N = 32
- NUM_SAMPLES, 4, dataset depth; must be ≥1
- ADDR_W, 2, sample index width; requires 2**ADDR_W ≥ NUM_SAMPLES
- EPOCH_W, 16, width of the epoch count

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- load_en_i  in  1  write one sample into the dataset
- load_addr_i  in  ADDR_W  sample slot to write
- load_x1_i, load_x2_i, load_target_i  in  W each  sample fields (Q15.16)
- num_epochs_i  in  EPOCH_W  epoch count, sampled at start
- start_i  in  1  begin streaming
- abort_i  in  1  stop streaming and return to IDLE
- ready_i  in  1  consumer accepts the current sample
- valid_o  out  1  sample outputs are valid
- x1_o, x2_o, target_o  out  W each  current sample
- sample_idx_o  out  ADDR_W  index of the presented sample
- epoch_o  out  EPOCH_W  current epoch, zero-based
- last_in_epoch_o  out  1  the presented sample is the final index of its epoch
- busy_o  out  1  state is STREAM
- done_o  out  1  all epochs streamed; held until start or abort

Behaviour:
- Reset:
  - State returns to IDLE.
  - All outputs go to 0.
  - Dataset memory is cleared to 0.
  - Epoch latch is cleared to 0.
- All outputs are registered. No combinational path from ready_i to valid_o.
- Loading:
  - A write takes effect only in IDLE or DONE, and only when load_addr_i < NUM_SAMPLES.
  - Otherwise the write is silently dropped.
  - Write latency is 1 cycle: a sample written in cycle N may be streamed from cycle N+1.
- FSM transitions:
  - IDLE → STREAM: start_i=1 and num_epochs_i ≠ 0. At the same edge, latch num_epochs_i, set idx=0 and epoch=0.
  - In the next cycle, valid_o=1 with sample 0.
  - If start_i=1 with num_epochs_i=0: go directly to DONE, done_o=1, no valid_o.
  - STREAM → STREAM: on a transfer (valid_o & ready_i), advance idx. When idx=NUM_SAMPLES-1, wrap idx to 0 and increment epoch.
  - The next sample appears in the following cycle with valid_o still 1, so back-to-back transfers have no bubble.
  - STREAM → DONE: transfer of idx=NUM_SAMPLES-1 in epoch=latched-1. Next cycle valid_o=0, busy_o=0, done_o=1. epoch_o holds the final epoch index.
  - DONE → STREAM: start_i, with the same semantics as from IDLE; done_o clears.
  - Any state → IDLE: abort_i, at the next edge. valid_o drops with no transfer completing that cycle. abort_i has priority over start_i and over a same-cycle transfer.
- Stability:
  - While valid_o=1 and ready_i=0, the outputs x1/x2/target/sample_idx/epoch/last_in_epoch stay constant.
  - valid_o never deasserts without a transfer, except on abort or reset.
- last_in_epoch_o = valid_o & (idx==NUM_SAMPLES-1).
- Epoch counter:
  - Never wraps, because the latched count bounds it.
  - num_epochs_i = 2**EPOCH_W-1 is legal.
- start_i while in STREAM is ignored.
- Reset mid-stream: immediate (asynchronous) clear. Dataset contents are lost.

Optional Feature:
- Macro: TRAIN_SEQ_SHUFFLE_EN.
- When defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) is seeded to 8'hA5 at reset and at each start.
  - The LFSR advances once per epoch boundary.
  - The presented slot is idx XOR lfsr[ADDR_W-1:0]. This is a permutation only when NUM_SAMPLES is a power of two; otherwise the mask is forced to 0.
  - sample_idx_o reports the physical slot.
  - last_in_epoch_o still follows the logical idx.
- When undefined: slots are presented in order 0..NUM_SAMPLES-1 and no LFSR exists.

Test Plan:
1. Load the AND dataset:
   - (0,0,0), (0,1.0,0), (1.0,0,0), (1.0,1.0,1.0), with 1.0 = 32'h0001_0000.
   - num_epochs=3, ready_i held 1.
   - Expect: 12 consecutive transfers; idx sequence 0,1,2,3 repeated 3×; epoch_o 0,1,2; last_in_epoch_o on every 4th transfer.
   - Expect: done_o=1 one cycle after the 12th transfer.
2. Same setup with ready_i toggled pseudo-randomly.
   - Expect: outputs are stable during every stall, exactly 12 transfers occur, and no sample is skipped or duplicated.
3. abort_i asserted during epoch 1, idx 2, with ready_i=1 in the same cycle.
   - Expect: next cycle valid_o=0, busy_o=0, done_o=0, and the idx-2 transfer is not counted.
   - Then start again → stream restarts at idx 0, epoch 0.
4. start_i with num_epochs_i=0.
   - Expect: DONE next cycle, valid_o never asserts.
   - Load at addr 5 (out of range) and a load during STREAM are both dropped; verify by streaming and checking the original data.
5. Assert reset_i asynchronously mid-transfer.
   - Expect: all outputs 0 within the same cycle.
   - Expect: streaming a fresh load with no reload returns zeros.
6. With TRAIN_SEQ_SHUFFLE_EN defined and NUM_SAMPLES=4, 2 epochs:
   - Expect: each epoch presents each slot 0..3 exactly once.
   - Expect: epoch 0 order equals idx XOR (8'hA5 & 3) = 1,0,3,2.

Source files
------------

// File: rtl/train_sample_sequencer.sv
// Replays a small (x1, x2, target) dataset over a valid/ready stream for N epochs.
// Optional slot shuffling per epoch when TRAIN_SEQ_SHUFFLE_EN is defined.
module train_sample_sequencer #(
  parameter int SIGN        = 1,
  parameter int Q_M         = 15,
  parameter int Q_N         = 16,
  parameter int NUM_SAMPLES = 4,
  parameter int ADDR_W      = 2,
  parameter int EPOCH_W     = 16,
  localparam int W          = SIGN + Q_M + Q_N
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_en_i,
  input  logic [ADDR_W-1:0]  load_addr_i,
  input  logic [W-1:0]       load_x1_i,
  input  logic [W-1:0]       load_x2_i,
  input  logic [W-1:0]       load_target_i,
  input  logic [EPOCH_W-1:0] num_epochs_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [W-1:0]       x1_o,
  output logic [W-1:0]       x2_o,
  output logic [W-1:0]       target_o,
  output logic [ADDR_W-1:0]  sample_idx_o,
  output logic [EPOCH_W-1:0] epoch_o,
  output logic               last_in_epoch_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int MEM_D = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_SAMPLES - 1);
  localparam logic [ADDR_W:0] NS = (ADDR_W + 1)'(NUM_SAMPLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic [EPOCH_W-1:0] num_q, num_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic [ADDR_W-1:0]  sidx_q;
  logic [W-1:0]       x1_q, x2_q, tg_q;
  logic               ld_d;
  logic [ADDR_W-1:0]  mask_d;
  logic [ADDR_W-1:0]  phys_d;

  logic [W-1:0] mem_x1_q [MEM_D];
  logic [W-1:0] mem_x2_q [MEM_D];
  logic [W-1:0] mem_tg_q [MEM_D];

  logic xfer;
  logic wr;

  assign xfer = valid_q & ready_i;
  assign wr   = load_en_i
              & (state_q != S_STREAM)
              & ({1'b0, load_addr_i} < NS);

`ifdef TRAIN_SEQ_SHUFFLE_EN
  // Mask is only a permutation of 0..N-1 when N is a power of two
  localparam bit POW2 = (NUM_SAMPLES & (NUM_SAMPLES - 1)) == 0;
  localparam logic [7:0] SEED = 8'hA5;

  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] lfsr_nx;

  assign lfsr_nx = {lfsr_q[6:0],
                    lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign mask_d  = POW2 ? (lfsr_d[ADDR_W-1:0] & LAST) : '0;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign mask_d = '0;
`endif

  assign phys_d = idx_d ^ mask_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    epoch_d = epoch_q;
    num_d   = num_q;
    valid_d = valid_q;
    ld_d    = 1'b0;
`ifdef TRAIN_SEQ_SHUFFLE_EN
    lfsr_d  = lfsr_q;
`endif
    if (abort_i) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            num_d   = num_epochs_i;
            idx_d   = '0;
            epoch_d = '0;
`ifdef TRAIN_SEQ_SHUFFLE_EN
            lfsr_d  = SEED;
`endif
            if (num_epochs_i != '0) begin
              state_d = S_STREAM;
              valid_d = 1'b1;
              ld_d    = 1'b1;
            end else begin
              state_d = S_DONE;
              valid_d = 1'b0;
            end
          end
        end
        S_STREAM: begin
          if (xfer) begin
            if (idx_q == LAST) begin
              if (epoch_q == num_q - 1'b1) begin
                state_d = S_DONE;
                valid_d = 1'b0;
              end else begin
                idx_d   = '0;
                epoch_d = epoch_q + 1'b1;
                ld_d    = 1'b1;
`ifdef TRAIN_SEQ_SHUFFLE_EN
                lfsr_d  = lfsr_nx;
`endif
              end
            end else begin
              idx_d = idx_q + 1'b1;
              ld_d  = 1'b1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
    last_d = valid_d & (idx_d == LAST);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      epoch_q <= '0;
      num_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      sidx_q  <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      tg_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      epoch_q <= epoch_d;
      num_q   <= num_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      if (ld_d) begin
        sidx_q <= phys_d;
        x1_q   <= mem_x1_q[phys_d];
        x2_q   <= mem_x2_q[phys_d];
        tg_q   <= mem_tg_q[phys_d];
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < MEM_D; i++) begin
        mem_x1_q[i] <= '0;
        mem_x2_q[i] <= '0;
        mem_tg_q[i] <= '0;
      end
    end else if (wr) begin
      mem_x1_q[load_addr_i] <= load_x1_i;
      mem_x2_q[load_addr_i] <= load_x2_i;
      mem_tg_q[load_addr_i] <= load_target_i;
    end
  end

  assign valid_o         = valid_q;
  assign x1_o            = x1_q;
  assign x2_o            = x2_q;
  assign target_o        = tg_q;
  assign sample_idx_o    = sidx_q;
  assign epoch_o         = epoch_q;
  assign last_in_epoch_o = last_q;
  assign busy_o          = state_q == S_STREAM;
  assign done_o          = state_q == S_DONE;

endmodule

// File: tb/tb_train_sample_sequencer.sv
// Directed bench for train_sample_sequencer: AND dataset replay, stalls,
// abort, zero epochs, dropped loads, async reset, optional shuffle order.
module tb_train_sample_sequencer;

  localparam int W  = 32;
  localparam int AW = 3;
  localparam int EW = 16;
  localparam int N  = 4;
  localparam logic [W-1:0] ONE = 32'h0001_0000;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          load_en_i;
  logic [AW-1:0] load_addr_i;
  logic [W-1:0]  load_x1_i, load_x2_i, load_target_i;
  logic [EW-1:0] num_epochs_i;
  logic          start_i, abort_i, ready_i;
  logic          valid_o;
  logic [W-1:0]  x1_o, x2_o, target_o;
  logic [AW-1:0] sample_idx_o;
  logic [EW-1:0] epoch_o;
  logic          last_in_epoch_o, busy_o, done_o;

  int nvec = 0;
  int nerr = 0;

  logic [W-1:0] ex1 [N];
  logic [W-1:0] ex2 [N];
  logic [W-1:0] etg [N];

  train_sample_sequencer #(
    .NUM_SAMPLES(N),
    .ADDR_W     (AW),
    .EPOCH_W    (EW)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .load_en_i      (load_en_i),
    .load_addr_i    (load_addr_i),
    .load_x1_i      (load_x1_i),
    .load_x2_i      (load_x2_i),
    .load_target_i  (load_target_i),
    .num_epochs_i   (num_epochs_i),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .ready_i        (ready_i),
    .valid_o        (valid_o),
    .x1_o           (x1_o),
    .x2_o           (x2_o),
    .target_o       (target_o),
    .sample_idx_o   (sample_idx_o),
    .epoch_o        (epoch_o),
    .last_in_epoch_o(last_in_epoch_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] phys(input int li, input int ep);
`ifdef TRAIN_SEQ_SHUFFLE_EN
    logic [7:0] l;
    l = 8'hA5;
    for (int e = 0; e < ep; e++)
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    return AW'(li) ^ AW'(l & 8'h03);
`else
    return AW'(li);
`endif
  endfunction

  function automatic logic [127:0] snap();
    return {valid_o, x1_o, x2_o, target_o,
            sample_idx_o, epoch_o, last_in_epoch_o};
  endfunction

  task automatic load(input logic [AW-1:0] a,
                      input logic [W-1:0] x1,
                      input logic [W-1:0] x2,
                      input logic [W-1:0] t);
    load_en_i     = 1'b1;
    load_addr_i   = a;
    load_x1_i     = x1;
    load_x2_i     = x2;
    load_target_i = t;
    @(negedge clk_i);
    load_en_i     = 1'b0;
  endtask

  task automatic kick(input int ne);
    start_i      = 1'b1;
    num_epochs_i = EW'(ne);
    @(negedge clk_i);
    start_i      = 1'b0;
  endtask

  task automatic run_stream(input int ne, input bit rnd, input bit inj);
    int xf;
    int cyc;
    int ep;
    int li;
    bit stall;
    logic [127:0] sv;
    logic [N-1:0] seen;
    logic [AW-1:0] p;
    xf    = 0;
    cyc   = 0;
    stall = 1'b0;
    sv    = '0;
    seen  = '0;
    kick(ne);
    while (xf < ne * N && cyc < 400) begin
      if (stall) chk("hold", snap(), sv);
      if (inj && xf == 1) begin
        load_en_i     = 1'b1;
        load_addr_i   = '0;
        load_x1_i     = 32'hDEAD_BEEF;
        load_x2_i     = 32'hDEAD_BEEF;
        load_target_i = 32'hDEAD_BEEF;
      end else begin
        load_en_i = 1'b0;
      end
      ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!rnd) chk("nobubble", valid_o, 1);
      if (valid_o && ready_i) begin
        ep = xf / N;
        li = xf % N;
        p  = phys(li, ep);
        chk("idx", sample_idx_o, p);
        chk("epoch", epoch_o, ep);
        chk("last", last_in_epoch_o, li == N - 1);
        chk("x1", x1_o, ex1[p]);
        chk("x2", x2_o, ex2[p]);
        chk("tgt", target_o, etg[p]);
        chk("busy", busy_o, 1);
        seen[p] = 1'b1;
        if (li == N - 1) begin
          chk("perm", seen, {N{1'b1}});
          seen = '0;
        end
        xf++;
      end
      stall = valid_o && !ready_i;
      sv    = snap();
      @(negedge clk_i);
      cyc++;
    end
    load_en_i = 1'b0;
    ready_i   = 1'b0;
    chk("xfers", xf, ne * N);
    chk("done", done_o, 1);
    chk("endvalid", valid_o, 0);
    chk("endbusy", busy_o, 0);
    chk("endepoch", epoch_o, ne - 1);
  endtask

  task automatic load_and();
    ex1[0] = '0;  ex2[0] = '0;  etg[0] = '0;
    ex1[1] = '0;  ex2[1] = ONE; etg[1] = '0;
    ex1[2] = ONE; ex2[2] = '0;  etg[2] = '0;
    ex1[3] = ONE; ex2[3] = ONE; etg[3] = ONE;
    for (int i = 0; i < N; i++)
      load(AW'(i), ex1[i], ex2[i], etg[i]);
  endtask

  initial begin
    int xf;
    int cyc;
    reset_i       = 1'b1;
    load_en_i     = 1'b0;
    load_addr_i   = '0;
    load_x1_i     = '0;
    load_x2_i     = '0;
    load_target_i = '0;
    num_epochs_i  = '0;
    start_i       = 1'b0;
    abort_i       = 1'b0;
    ready_i       = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_valid", valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_data", {x1_o, x2_o, target_o}, 0);
    chk("rst_epoch", epoch_o, 0);
    reset_i = 1'b0;
    @(negedge clk_i);

    load_and();
    run_stream(3, 1'b0, 1'b0);
    run_stream(3, 1'b1, 1'b0);

    // abort at epoch 1, idx 2 with ready high
    kick(3);
    xf  = 0;
    cyc = 0;
    ready_i = 1'b1;
    while (xf < 6 && cyc < 100) begin
      if (valid_o) xf++;
      @(negedge clk_i);
      cyc++;
    end
    chk("abort_reach", xf, 6);
    chk("abort_ep", epoch_o, 1);
    chk("abort_last", last_in_epoch_o, 0);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    ready_i = 1'b0;
    chk("abort_valid", valid_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_done", done_o, 0);
    run_stream(3, 1'b0, 1'b0);

    // zero epochs, dropped loads
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    chk("idle_done", done_o, 0);
    kick(0);
    chk("zero_done", done_o, 1);
    for (int i = 0; i < 3; i++) begin
      chk("zero_valid", valid_o, 0);
      @(negedge clk_i);
    end
    load(3'd5, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678);
    run_stream(1, 1'b0, 1'b1);
    run_stream(1, 1'b0, 1'b0);

    // asynchronous reset mid-stream
    kick(2);
    ready_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    #2 reset_i = 1'b1;
    #1;
    chk("arst_valid", valid_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_data", {x1_o, x2_o, target_o}, 0);
    chk("arst_idx", {sample_idx_o, epoch_o, last_in_epoch_o}, 0);
    @(negedge clk_i);
    reset_i = 1'b0;
    ready_i = 1'b0;
    @(negedge clk_i);
    for (int i = 0; i < N; i++) begin
      ex1[i] = '0;
      ex2[i] = '0;
      etg[i] = '0;
    end
    run_stream(2, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
